// File: rtl/sa_tile_sequencer.sv
// Tiled sequencer for a CH x CH systolic array: streams A/B tiles from SRAM,
// skews each lane diagonally into the array, drains, then commands C write-back.
module sa_tile_sequencer #(
    parameter int CH        = 4,
    parameter int DW        = 8,
    parameter int K_LEN     = 16,
    parameter int N_TILES   = 32,
    parameter int DRAIN_CYC = 12,
    parameter int AW        = 9,
    parameter int TW        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               finish,
    output logic               mem_re,
    output logic [AW-1:0]      mem_addr,
    input  logic [CH*DW-1:0]   a_rdata,
    input  logic [CH*DW-1:0]   b_rdata,
    output logic [CH*DW-1:0]   arr_a,
    output logic [CH*DW-1:0]   arr_b,
    output logic [CH-1:0]      arr_vld,
    output logic               c_we,
    output logic [TW-1:0]      c_addr,
    output logic               acc_clr
);

    localparam int FW  = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam int DCW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_WB,
        S_CLR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  f_q;
    logic [DCW-1:0] d_q;
    logic [TW-1:0]  tile_q;
    logic [AW-1:0]  addr_q;
    logic           re_p0;

    logic feed_last, drain_last, tile_last;

    assign feed_last  = (f_q == FW'(K_LEN - 1));
    assign drain_last = (d_q == DCW'(DRAIN_CYC - 1));
    assign tile_last  = (tile_q == TW'(N_TILES - 1));
    assign mem_addr   = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        finish  = 1'b0;
        mem_re  = 1'b0;
        c_we    = 1'b0;
        c_addr  = '0;
        acc_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FEED;
            end
            S_FEED: begin
                busy   = 1'b1;
                mem_re = 1'b1;
                if (feed_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_last) state_d = S_WB;
            end
            S_WB: begin
                busy    = 1'b1;
                c_we    = 1'b1;
                c_addr  = tile_q;
                state_d = S_CLR;
            end
            S_CLR: begin
                busy    = 1'b1;
                acc_clr = 1'b1;
                state_d = tile_last ? S_DONE : S_FEED;
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address is a running counter; it advances between reads only, so it
    // holds the last issued address through DRAIN/WB/CLR and after the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q    <= '0;
            d_q    <= '0;
            tile_q <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f_q    <= '0;
                        tile_q <= '0;
                        addr_q <= '0;
                    end
                end
                S_FEED: begin
                    if (feed_last) begin
                        f_q <= '0;
                        d_q <= '0;
                    end else begin
                        f_q    <= f_q + FW'(1);
                        addr_q <= addr_q + AW'(1);
                    end
                end
                S_DRAIN: d_q <= d_q + DCW'(1);
                S_CLR: begin
                    tile_q <= tile_q + TW'(1);
                    if (!tile_last) addr_q <= addr_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Stage p0: SRAM read data becomes valid one cycle after mem_re.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_p0 <= 1'b0;
        end else begin
            re_p0 <= mem_re;
        end
    end

    // Skew stages: lane k carries k extra registers behind its capture stage.
    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic [k:0][DW-1:0] a_p1;
        logic [k:0][DW-1:0] b_p1;
        logic [k:0]         vld_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_p1   <= '0;
                b_p1   <= '0;
                vld_p1 <= '0;
            end else begin
                a_p1[0]   <= a_rdata[k*DW +: DW];
                b_p1[0]   <= b_rdata[k*DW +: DW];
                vld_p1[0] <= re_p0;
                for (int j = 1; j <= k; j++) begin
                    a_p1[j]   <= a_p1[j-1];
                    b_p1[j]   <= b_p1[j-1];
                    vld_p1[j] <= vld_p1[j-1];
                end
            end
        end

        assign arr_vld[k]          = vld_p1[k];
        assign arr_a[k*DW +: DW]   = vld_p1[k] ? a_p1[k] : '0;
        assign arr_b[k*DW +: DW]   = vld_p1[k] ? b_p1[k] : '0;
    end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Bench for sa_tile_sequencer: random SRAM data and start pulses against a
// schedule model derived from run-relative cycle arithmetic.
module tb_sa_tile_sequencer;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int K  = 16;
    localparam int NT = 2;
    localparam int DC = 12;
    localparam int AW = 9;
    localparam int TW = 5;
    localparam int LW = CH * DW;
    localparam int P  = K + DC + 2;
    localparam int NP = NT * P;
    localparam int HN = 2048;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          finish;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] a_rdata;
    logic [LW-1:0] b_rdata;
    logic [LW-1:0] arr_a;
    logic [LW-1:0] arr_b;
    logic [CH-1:0] arr_vld;
    logic          c_we;
    logic [TW-1:0] c_addr;
    logic          acc_clr;

    sa_tile_sequencer #(
        .CH(CH), .DW(DW), .K_LEN(K), .N_TILES(NT), .DRAIN_CYC(DC), .AW(AW), .TW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .finish(finish),
        .mem_re(mem_re), .mem_addr(mem_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .arr_a(arr_a), .arr_b(arr_b), .arr_vld(arr_vld), .c_we(c_we), .c_addr(c_addr),
        .acc_clr(acc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            ncmp = 0;
    int            nerr = 0;
    int            n = 0;
    int            s = 0;
    int            fin_cnt = 0;
    bit            active = 0;
    logic [AW-1:0] exp_addr = '0;
    bit            hre [HN];
    logic [LW-1:0] hda [HN];
    logic [LW-1:0] hdb [HN];
    logic [LW-1:0] mem_a [NT*K];
    logic [LW-1:0] mem_b [NT*K];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},    64'(busy),     64'(0));
        chk({tag, ".finish"},  64'(finish),   64'(0));
        chk({tag, ".mem_re"},  64'(mem_re),   64'(0));
        chk({tag, ".mem_addr"},64'(mem_addr), 64'(0));
        chk({tag, ".arr_a"},   64'(arr_a),    64'(0));
        chk({tag, ".arr_b"},   64'(arr_b),    64'(0));
        chk({tag, ".arr_vld"}, 64'(arr_vld),  64'(0));
        chk({tag, ".c_we"},    64'(c_we),     64'(0));
        chk({tag, ".c_addr"},  64'(c_addr),   64'(0));
        chk({tag, ".acc_clr"}, 64'(acc_clr),  64'(0));
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NT*K; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
    endtask

    // One clock: drive start, emulate the SRAM, advance the model, compare.
    task automatic cycle(input bit st);
        bit            re_s;
        logic [AW-1:0] ad_s;
        bit            ere, ebusy, efin, ecwe, eclr;
        logic [TW-1:0] ecaddr;
        logic [CH-1:0] evld;
        logic [LW-1:0] ea, eb;
        int            j, ph, tile, c;
        start = st;
        @(negedge clk);
        re_s = mem_re;
        ad_s = mem_addr;
        @(posedge clk);
        n++;
        if (n >= HN) begin
            $display("FAIL history_overflow: cycle %0d limit %0d", n, HN);
            $fatal(1, "bench cycle budget exceeded");
        end
        if (rst_n && st && (!active || (n - 1 - s) > NP)) begin
            active = 1;
            s = n;
        end
        #1;
        if (re_s) begin
            a_rdata = mem_a[ad_s];
            b_rdata = mem_b[ad_s];
        end else begin
            a_rdata = $urandom;
            b_rdata = $urandom;
        end
        ere = 0; ebusy = 0; efin = 0; ecwe = 0; eclr = 0; ecaddr = '0;
        evld = '0; ea = '0; eb = '0;
        if (!rst_n) begin
            active = 0;
            exp_addr = '0;
            for (int i = 0; i < HN; i++) hre[i] = 0;
        end else if (active) begin
            j = n - s;
            if (j < NP) begin
                ebusy = 1;
                ph = j % P;
                tile = j / P;
                if (ph < K) begin
                    ere = 1;
                    exp_addr = AW'(tile * K + ph);
                end
                ecwe = (ph == K + DC);
                eclr = (ph == K + DC + 1);
                ecaddr = TW'(tile);
            end else if (j == NP) begin
                efin = 1;
            end
        end
        hre[n] = ere;
        hda[n] = ere ? mem_a[exp_addr] : '0;
        hdb[n] = ere ? mem_b[exp_addr] : '0;
        for (int k = 0; k < CH; k++) begin
            c = n - 2 - k;
            if (rst_n && c >= 0 && hre[c]) begin
                evld[k] = 1'b1;
                ea[k*DW +: DW] = hda[c][k*DW +: DW];
                eb[k*DW +: DW] = hdb[c][k*DW +: DW];
            end
        end
        chk("mem_re",   64'(mem_re),   64'(ere));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        chk("busy",     64'(busy),     64'(ebusy));
        chk("finish",   64'(finish),   64'(efin));
        chk("c_we",     64'(c_we),     64'(ecwe));
        if (ecwe) chk("c_addr", 64'(c_addr), 64'(ecaddr));
        chk("acc_clr",  64'(acc_clr),  64'(eclr));
        chk("arr_vld",  64'(arr_vld),  64'(evld));
        chk("arr_a",    64'(arr_a),    64'(ea));
        chk("arr_b",    64'(arr_b),    64'(eb));
        if (finish) fin_cnt++;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a_rdata = '0;
        b_rdata = '0;
        for (int i = 0; i < HN; i++) hre[i] = 0;
        fill_mem();

        // Power-on reset and quiet idle
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) cycle(1'b0);
        rst_n = 1'b1;
        repeat (20) cycle(1'b0);

        // First run with stray starts while busy
        fin_cnt = 0;
        cycle(1'b1);
        for (int i = 1; i <= NP + 1; i++) cycle(i == 5 || i == 40);
        chk("finish_count_run1", 64'(fin_cnt), 64'(1));

        // Back-to-back: start in the cycle after finish
        fin_cnt = 0;
        cycle(1'b1);
        for (int i = 1; i <= NP + 1; i++) cycle(1'b0);
        chk("finish_count_b2b", 64'(fin_cnt), 64'(1));

        // Random start traffic with fresh data
        repeat (8) cycle(1'b0);
        fill_mem();
        repeat (300) cycle($urandom_range(0, 24) == 0);
        repeat (NP + 4) cycle(1'b0);

        // Abort during the second tile's drain
        fin_cnt = 0;
        cycle(1'b1);
        for (int i = 1; i <= P + K + 3; i++) cycle(1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_mid");
        repeat (6) cycle(1'b0);
        rst_n = 1'b1;
        repeat (NP + 5) cycle(1'b0);
        chk("finish_count_abort", 64'(fin_cnt), 64'(0));

        // Restart after abort begins again at address 0
        fin_cnt = 0;
        cycle(1'b1);
        chk("restart_addr", 64'(mem_addr), 64'(0));
        for (int i = 1; i <= NP + 2; i++) cycle(1'b0);
        chk("finish_count_restart", 64'(fin_cnt), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
